// File: rtl/encoder_pkg.sv
// encoder_pkg: shared FSM state encoding and default index width for the serializing encoder.
package encoder_pkg;
    localparam int OP_WIDTH_DEF = 4;
    typedef enum logic {ST_IDLE, ST_BUSY} state_e;
endpackage

// File: rtl/encoder_if.sv
// encoder_if: request-vector capture stream and binary-index output stream of the encoder.
interface encoder_if
    import encoder_pkg::*;
#(parameter int OP_WIDTH = OP_WIDTH_DEF);
    localparam int IP_WIDTH = 1 << OP_WIDTH;
    logic                in_valid;
    logic                in_ready;
    logic [IP_WIDTH-1:0] i;
    logic                y_valid;
    logic                y_ready;
    logic [OP_WIDTH-1:0] y;
    logic                y_last;
    modport master (output in_valid, i, y_ready, input in_ready, y_valid, y, y_last);
    modport slave  (input in_valid, i, y_ready, output in_ready, y_valid, y, y_last);
endinterface

// File: rtl/encoder_priority_encoder_lsb.sv
// priority_encoder_lsb: vector -> {any bit set, index of lowest set bit, exactly one bit set}.
module priority_encoder_lsb #(
    parameter int OP_WIDTH = 4
) (
    input  logic [(1<<OP_WIDTH)-1:0] vec_i,
    output logic                     found_o,
    output logic [OP_WIDTH-1:0]      idx_o,
    output logic                     one_o
);
    localparam int IP_WIDTH = 1 << OP_WIDTH;
    // Scanning downward lets the lowest set bit win the last assignment.
    always_comb begin
        idx_o = '0;
        for (int k = IP_WIDTH - 1; k >= 0; k--)
            if (vec_i[k]) idx_o = OP_WIDTH'(k);
    end
    assign found_o = |vec_i;
    assign one_o   = found_o && ((vec_i & (vec_i - IP_WIDTH'(1))) == '0);
endmodule

// File: rtl/encoder.sv
// encoder: captures a multi-hot request vector and streams the binary index of each set bit,
// lowest first, one per accepted beat.
module encoder
    import encoder_pkg::*;
#(
    parameter int OP_WIDTH = OP_WIDTH_DEF
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      en_i,
    encoder_if.slave  bus
);
    localparam int IP_WIDTH = 1 << OP_WIDTH;
    state_e              state_q, state_d;
    logic [IP_WIDTH-1:0] pend_q, pend_d, pend_next, pe_in;
    logic [OP_WIDTH-1:0] y_q, y_d, pe_idx;
    logic                y_valid_q, y_valid_d, y_last_q, y_last_d;
    logic                pe_found, pe_one, capture, accept;
    assign bus.in_ready = en_i & (state_q == ST_IDLE) & ~rst;
    assign capture      = bus.in_valid & bus.in_ready;
    assign accept       = y_valid_q & bus.y_ready;
    // pend keeps the presented bit until it is accepted, so clearing it here yields the remainder.
    assign pend_next    = pend_q & ~(IP_WIDTH'(1) << y_q);
    assign pe_in        = capture ? bus.i : accept ? pend_next : pend_q;
    priority_encoder_lsb #(.OP_WIDTH(OP_WIDTH)) u_pe (
        .vec_i   (pe_in),
        .found_o (pe_found),
        .idx_o   (pe_idx),
        .one_o   (pe_one)
    );
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        y_d       = y_q;
        y_valid_d = y_valid_q;
        y_last_d  = y_last_q;
        if (state_q == ST_IDLE) begin
            if (capture && pe_found) begin
                state_d   = ST_BUSY;
                pend_d    = bus.i;
                y_d       = pe_idx;
                y_last_d  = pe_one;
                y_valid_d = 1'b1;
            end
        end else if (accept) begin
            if (y_last_q) begin
                state_d   = ST_IDLE;
                pend_d    = '0;
                y_valid_d = 1'b0;
            end else begin
                pend_d    = pend_next;
                y_valid_d = en_i;
                y_d       = en_i ? pe_idx : y_q;
                y_last_d  = en_i ? pe_one : y_last_q;
            end
        end else if (!y_valid_q && en_i) begin
            y_d       = pe_idx;
            y_last_d  = pe_one;
            y_valid_d = 1'b1;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pend_q    <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            y_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            y_last_q  <= y_last_d;
        end
    end
    assign bus.y       = y_q;
    assign bus.y_valid = y_valid_q;
    assign bus.y_last  = y_last_q;
endmodule
